// File: rtl/div_iter.sv
// div_iter: iterative restoring divider (1 quotient bit/cycle); in: in_valid/in_ready, is_signed, dividend, divisor, flush; out: out_valid/out_ready, quotient, remainder, div_by_zero, busy
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, b, pr, pr_nx, q_fin;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] shifted, diff;
  logic q_neg, r_neg, q_bit, last, accept, neg_a, neg_b;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == CALC;
  assign accept    = in_ready && in_valid && !flush;
  assign last      = cnt == CW'(WIDTH - 1);
  assign neg_a     = is_signed & dividend[WIDTH-1];
  assign neg_b     = is_signed & divisor[WIDTH-1];
  assign shifted   = {pr, a[WIDTH-1]};
  assign diff      = shifted - {1'b0, b};
  assign q_bit     = !diff[WIDTH];
  assign pr_nx     = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_fin     = {a[WIDTH-2:0], q_bit};
  always_comb begin
    state_nx = flush ? IDLE :
               accept ? (divisor == '0 ? DONE : CALC) :
               (state == CALC && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a           <= '0;
      b           <= '0;
      pr          <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a     <= neg_a ? -dividend : dividend;
      b     <= neg_b ? -divisor : divisor;
      pr    <= '0;
      cnt   <= '0;
      q_neg <= neg_a ^ neg_b;
      r_neg <= neg_a;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC && !flush) begin
      a   <= q_fin;
      pr  <= pr_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient    <= q_neg ? -q_fin : q_fin;
        remainder   <= r_neg ? -pr_nx : pr_nx;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter against an arithmetic reference model
module tb_div_iter;
  localparam int W = 32;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, is_signed = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, busy, div_by_zero;
  logic [W-1:0] quotient, remainder;
  int errors = 0, checks = 0;
  typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic z;} res_t;
  res_t exp_q[$];
  res_t e;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t m;
    longint sa, sd, qq, rr;
    if (b == '0) begin
      m.q = '1; m.r = a; m.z = 1'b1;
    end else if (!s) begin
      m.q = a / b; m.r = a % b; m.z = 1'b0;
    end else begin
      sa = $signed(a); sd = $signed(b);
      qq = sa / sd; rr = sa % sd;
      m.q = qq[W-1:0]; m.r = rr[W-1:0]; m.z = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=%h r=%h expected none", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", W'(div_by_zero), W'(e.z));
      end
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick;
      n++;
    end
    chk("in_ready_before_accept", W'(in_ready), 1);
    in_valid = 1'b1; dividend = a; divisor = b; is_signed = s;
    if (push) exp_q.push_back(model(a, b, s));
    tick;
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  task automatic wait_result(input logic dbz);
    int lat = 0, bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      tick;
      lat++;
    end
    chk(dbz ? "dbz_latency" : "latency", lat, dbz ? 0 : W);
    chk("busy_cycles", bc, dbz ? 0 : W);
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("in_ready_after_handoff", W'(in_ready), 1);
    chk("out_valid_after_handoff", W'(out_valid), 0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start(a, b, s, 1'b1);
    wait_result(b == '0);
    repeat ($urandom_range(0, 3)) tick;
    consume;
  endtask

  task automatic check_reset_outputs(input string n);
    chk({n, "_in_ready"}, W'(in_ready), 1);
    chk({n, "_out_valid"}, W'(out_valid), 0);
    chk({n, "_busy"}, W'(busy), 0);
    chk({n, "_quotient"}, quotient, 0);
    chk({n, "_remainder"}, remainder, 0);
    chk({n, "_div_by_zero"}, W'(div_by_zero), 0);
  endtask

  initial begin
    logic [W-1:0] q0, r0, a, b;
    logic seen;
    repeat (3) tick;
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick;
    run(100, 7, 1'b0);
    run(32'hFFFFFFFF, 32'h10, 1'b0);
    run(-32'd7, 2, 1'b1);
    run(7, -32'd2, 1'b1);
    run(-32'd7, -32'd2, 1'b1);
    run(32'h80000000, 32'hFFFFFFFF, 1'b1);
    run(32'h80000000, 32'hFFFFFFFF, 1'b0);
    run(0, 5, 1'b0);
    run(32'h12345678, 0, 1'b1);
    run(32'h12345678, 0, 1'b0);
    run(1000, 3, 1'b0);
    start(500, 9, 1'b0, 1'b1);
    wait_result(1'b0);
    q0 = quotient; r0 = remainder;
    repeat (10) begin
      in_valid = 1'b1; dividend = $urandom; divisor = $urandom;
      tick;
      chk("bp_quotient_stable", quotient, q0);
      chk("bp_remainder_stable", remainder, r0);
      chk("bp_in_ready", W'(in_ready), 0);
      chk("bp_out_valid", W'(out_valid), 1);
    end
    in_valid = 1'b0;
    consume;
    run(77, 5, 1'b0);
    start(12345, 67, 1'b0, 1'b0);
    repeat (5) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_calc_in_ready", W'(in_ready), 1);
    chk("flush_calc_busy", W'(busy), 0);
    seen = 1'b0;
    repeat (40) begin
      tick;
      seen |= out_valid;
    end
    chk("flush_calc_no_valid", W'(seen), 0);
    run(-32'd1000, 33, 1'b1);
    in_valid = 1'b1; dividend = 50; divisor = 5; flush = 1'b1;
    tick;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_in_ready", W'(in_ready), 1);
    chk("flush_idle_busy", W'(busy), 0);
    chk("flush_idle_out_valid", W'(out_valid), 0);
    run(50, 6, 1'b0);
    start(999, 10, 1'b1, 1'b0);
    wait_result(1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_done_out_valid", W'(out_valid), 0);
    chk("flush_done_in_ready", W'(in_ready), 1);
    run(999, -32'd10, 1'b1);
    start(-32'd100, 7, 1'b1, 1'b0);
    repeat (10) tick;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    tick;
    run(-32'd100, 7, 1'b1);
    repeat (30) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = -W'($urandom_range(1, 15));
      endcase
      run(a, b, 1'($urandom));
    end
    repeat (3) tick;
    chk("scoreboard_empty", W'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative integer divider for the CPU's HI/LO unit. It supersedes the fixed 32-bit start/end divider with a `WIDTH` parameter, valid/ready handshakes on both sides, and a result held until the consumer accepts it. It also adds a pipeline-flush cancel and a defined divide-by-zero fast path. It sits beside the multiplier in the execute stage and produces one quotient bit per cycle using restoring division on operand magnitudes.

## Interface
- `WIDTH`, default 32, operand/result width (≥ 2)
- `clk` in 1, sole clock, rising edge
- `resetn` in 1, reset is asynchronous and active-low
- `in_valid` in 1, operands presented
- `in_ready` out 1, divider can accept; equals (state == IDLE)
- `is_signed` in 1, 1 = two's-complement operands, 0 = unsigned; sampled at accept
- `dividend` in WIDTH, numerator; sampled at accept
- `divisor` in WIDTH, denominator; sampled at accept
- `flush` in 1, cancel any operation in progress or pending result
- `out_valid` out 1, result available; equals (state == DONE)
- `out_ready` in 1, consumer takes result
- `quotient` out WIDTH, registered quotient
- `remainder` out WIDTH, registered remainder
- `div_by_zero` out 1, registered flag: current result came from a zero divisor
- `busy` out 1, equals (state == CALC)

## Operation
- States are IDLE, CALC and DONE. Reset puts the block in IDLE with `quotient`, `remainder` and `div_by_zero` at 0. This gives `in_ready`=1, `out_valid`=0 and `busy`=0.
- **Accept:** occurs at a rising edge where `in_valid && in_ready && !flush`. At that edge the block latches:
  - the magnitudes of the operands; in signed mode a negative operand is replaced by its two's-complement negation, a WIDTH-bit value;
  - `q_neg` = `is_signed` & (dividend MSB ^ divisor MSB);
  - `r_neg` = `is_signed` & dividend MSB;
  - the raw dividend.
- **Normal path (divisor ≠ 0):** accept leads to CALC with an iteration counter of 0.
  - Each CALC cycle: partial remainder (WIDTH+1 bits) = {partial remainder, next dividend-magnitude bit, MSB first} minus divisor magnitude.
  - If that result is non-negative, it is kept and the quotient bit is 1. Otherwise the previous shifted value is restored and the quotient bit is 0.
  - After iteration WIDTH−1 the block goes to DONE. The `quotient` and `remainder` registers are loaded with the signed corrections: quotient negated if `q_neg`, remainder negated if `r_neg`. `div_by_zero` = 0.
- **Signed semantics:** truncation toward zero; the remainder takes the dividend's sign. MIN / −1 yields quotient = MIN and remainder = 0, which falls out of WIDTH-bit wrap. No overflow flag.
- **Divide-by-zero:** accept leads directly to DONE, skipping CALC. Outputs are `quotient` = all ones, `remainder` = raw dividend and `div_by_zero` = 1, in both modes.
- **DONE:** outputs are held stable while `out_ready`=0. At an edge with `out_ready`=1 the block returns to IDLE. Output registers keep their values until the next result loads; only `out_valid` qualifies them.
- **Flush:** `flush`=1 at any edge forces IDLE, whatever `in_valid` or `out_ready` are doing.
  - A result pending in DONE is discarded and `out_valid` falls.
  - Flush beats accept in the same cycle.
  - Output registers are not cleared.
- **Asynchronous reset:** `resetn` low at any time, including mid-CALC, immediately forces the reset state. Nothing resumes after release.

## Timing
- Accept at edge E0. Normal result: `out_valid` rises after edge E0+WIDTH, so latency is WIDTH cycles (32 for the default).
- Divide-by-zero: `out_valid` rises after E0+1.
- A result handed off at edge Ed puts the block in IDLE: `in_ready`=1 in the cycle after Ed. Next accept at the earliest at Ed+1, so no back-to-back issue. Minimum issue interval is WIDTH+2 cycles.
- `in_ready`, `out_valid` and `busy` are pure decodes of the state register, with no combinational path from any input.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE. Operand changes after accept have no effect.

## Test plan
- **Unsigned basic:** unsigned 100 / 7, then 0xFFFFFFFF / 0x10. Require q=14, r=2, then q=0x0FFFFFFF, r=0xF. `out_valid` must be exactly 32 cycles after the handshake; `busy` is high for 32 cycles.
- **Signed sign cases:** signed operand pairs. Require:
  - −7 / 2 gives q=0xFFFFFFFD, r=0xFFFFFFFF;
  - 7 / −2 gives q=0xFFFFFFFD, r=1;
  - −7 / −2 gives q=3, r=0xFFFFFFFF.
- **Boundary operands:** 0x80000000 / 0xFFFFFFFF. Signed requires q=0x80000000, r=0; unsigned requires q=0, r=0x80000000. 0 / 5 gives q=0, r=0.
- **Divide-by-zero:** 0x12345678 / 0, signed and unsigned. Require `out_valid` one cycle after accept, `div_by_zero`=1, q=0xFFFFFFFF, r=0x12345678. The next normal divide must return `div_by_zero`=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE. `quotient`/`remainder` must stay stable, `in_ready` must stay 0, and `in_valid` pulses must be ignored. Raising `out_ready` gives IDLE next cycle, and a new accept on the following edge must be correct.
- **Cancel:**
  - `flush` in CALC iteration 5: `out_valid` never asserts and `in_ready`=1 the next cycle.
  - `flush` together with `in_valid` in IDLE: no accept.
  - `flush` in DONE: result dropped.
  - `resetn` pulsed low mid-CALC: all outputs return to reset values immediately.
  - The following divide must be correct in every case.
